// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the three buses around the shared memory port:
//     - fetch requester : if_req, if_addr -> if_rdata, if_ready
//     - data requester  : dm_req, dm_we, dm_addr, dm_wdata -> dm_rdata, dm_ready
//     - memory port     : mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ack
//     - status          : bus_err (abort pulse), pipe_stall (combinational stall)
//   slave  : the arbiter's view (drives ready/data/memory request side)
//   master : the surrounding CPU/memory view (drives requests and ack)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;

  logic        dm_req;
  logic        dm_we;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic [63:0] dm_rdata;
  logic        dm_ready;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  logic        bus_err;
  logic        pipe_stall;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    output if_rdata, if_ready, dm_rdata, dm_ready,
    output mem_req, mem_we, mem_addr, mem_wdata, bus_err, pipe_stall
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
    input  if_rdata, if_ready, dm_rdata, dm_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata, bus_err, pipe_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one 64-bit memory port between instruction fetch (IF) and the
//   MEM-stage data access (DM). One transaction is outstanding at a time:
//   IDLE grants, BUSY_IF/BUSY_DM hold the request until mem_ack (or the
//   watchdog fires), RESP pulses the owner's ready for one cycle.
//   Data accesses win arbitration, except after MAX_DM_BURST consecutive
//   DM grants taken while a fetch was waiting, at which point fetch goes next.
//
// Parameters
//   MAX_DM_BURST : DM grants allowed back-to-back while a fetch waits (>= 1)
//   TIMEOUT      : BUSY cycles without mem_ack before abort (1..255)
// Ports
//   clk  : clock, all state on rising edge
//   rst  : synchronous active-high reset
//   bus  : mem_port_arbiter_if.slave (fetch, data, memory and status signals)
module mem_port_arbiter #(
  parameter int MAX_DM_BURST = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  localparam int                 BURST_W   = $clog2(MAX_DM_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DM_BURST);
  localparam logic [7:0]         WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t               state_q,     state_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [7:0]           wait_cnt_q,  wait_cnt_d;
  logic                 mem_req_q,   mem_req_d;
  logic                 mem_we_q,    mem_we_d;
  logic [63:0]          mem_addr_q,  mem_addr_d;
  logic [63:0]          mem_wdata_q, mem_wdata_d;
  logic [31:0]          if_rdata_q,  if_rdata_d;
  logic [63:0]          dm_rdata_q,  dm_rdata_d;
  logic                 if_ready_q,  if_ready_d;
  logic                 dm_ready_q,  dm_ready_d;
  logic                 bus_err_q,   bus_err_d;

  // Saturating increment of the DM burst counter.
  function automatic logic [BURST_W-1:0] burst_sat_inc(input logic [BURST_W-1:0] cnt);
    if (cnt >= BURST_MAX) begin
      return BURST_MAX;
    end
    return cnt + BURST_W'(1);
  endfunction

  // Picks the 32-bit instruction out of the 64-bit memory beat.
  function automatic logic [31:0] fetch_word(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    bus_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Grant stage: DM first unless a waiting fetch has used up its patience.
        if (bus.dm_req && (!bus.if_req || (burst_cnt_q < BURST_MAX))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.dm_we;
          mem_addr_d  = bus.dm_addr & ~64'h7;
          mem_wdata_d = bus.dm_wdata;
          wait_cnt_d  = 8'd0;
          burst_cnt_d = bus.if_req ? burst_sat_inc(burst_cnt_q) : '0;
        end else if (bus.if_req) begin
          state_d     = BUSY_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = bus.if_addr & ~64'h3;
          wait_cnt_d  = 8'd0;
          burst_cnt_d = '0;
        end
      end

      BUSY_IF, BUSY_DM: begin
        // Memory stage: completion by ack, or forced completion by watchdog.
        if (bus.mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = fetch_word(bus.mem_rdata, mem_addr_q[2]);
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = bus.mem_rdata;
            end
          end
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Abort: the requester still gets its ready, with zeroed read data.
          state_d   = RESP;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
          if (state_q == BUSY_IF) begin
            if_ready_d = 1'b1;
            if_rdata_d = 32'd0;
          end else begin
            dm_ready_d = 1'b1;
            if (!mem_we_q) begin
              dm_rdata_d = 64'd0;
            end
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      RESP: begin
        // Ready pulse is visible this cycle; the still-high req must not re-grant.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      burst_cnt_q <= '0;
      wait_cnt_q  <= 8'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      if_rdata_q  <= 32'd0;
      dm_rdata_q  <= 64'd0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.if_rdata   = if_rdata_q;
  assign bus.if_ready   = if_ready_q;
  assign bus.dm_rdata   = dm_rdata_q;
  assign bus.dm_ready   = dm_ready_q;
  assign bus.bus_err    = bus_err_q;
  assign bus.pipe_stall = (bus.if_req & ~if_ready_q) | (bus.dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int MAXB = 4;
  localparam int TO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(.MAX_DM_BURST(MAXB), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout sim did not finish, got running want finished");
    $fatal(1, "global timeout");
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = 64'd0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = 64'd0;
    bus.dm_wdata  = 64'd0;
    bus.mem_rdata = 64'd0;
    bus.mem_ack   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.if_ready, bus.dm_ready, bus.bus_err} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b want 00000",
               {bus.mem_req, bus.mem_we, bus.if_ready, bus.dm_ready, bus.bus_err});
    end
    n_tests++;
    if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata} !== 224'd0) begin
      n_fail++;
      $display("FAIL reset_data got %h %h %h %h want zeros",
               bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata);
    end
    bus.if_req = 1'b1;
    settle();
    n_tests++;
    if (bus.pipe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stall_follows got %b want 1", bus.pipe_stall);
    end
    bus.if_req = 1'b0;
    step();
    rst = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hFFFF_0000_FFFF_0000;
    step();
    bus.mem_ack = 1'b0;
    step();
    n_tests++;
    if ({bus.mem_req, bus.if_ready, bus.dm_ready, bus.bus_err, bus.dm_rdata} !== 68'd0) begin
      n_fail++;
      $display("FAIL reset_stray_ack got req=%b ifr=%b dmr=%b err=%b dmd=%h want all 0",
               bus.mem_req, bus.if_ready, bus.dm_ready, bus.bus_err, bus.dm_rdata);
    end
  endtask

  task automatic test_fetch();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h104;
    step();  // cycle 1
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 64'h104}) begin
      n_fail++;
      $display("FAIL fetch_grant got req=%b we=%b addr=%h want 1 0 104",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    step();  // cycle 2
    n_tests++;
    if ({bus.mem_req, bus.mem_addr, bus.if_ready} !== {1'b1, 64'h104, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_hold got req=%b addr=%h ifr=%b want 1 104 0",
               bus.mem_req, bus.mem_addr, bus.if_ready);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hAAAA_BBBB_1111_2222;
    step();  // cycle 3
    bus.mem_ack = 1'b0;
    n_tests++;
    if ({bus.if_ready, bus.if_rdata, bus.mem_req, bus.dm_ready, bus.bus_err}
        !== {1'b1, 32'hAAAA_BBBB, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL fetch_resp got ifr=%b data=%h req=%b dmr=%b err=%b want 1 aaaabbbb 0 0 0",
               bus.if_ready, bus.if_rdata, bus.mem_req, bus.dm_ready, bus.bus_err);
    end
    step();  // cycle 4
    bus.if_req = 1'b0;
    n_tests++;
    if ({bus.if_ready, bus.mem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_idle got ifr=%b req=%b want 0 0", bus.if_ready, bus.mem_req);
    end
    step();
  endtask

  task automatic test_dm_priority();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_addr  = 64'h40;
    bus.dm_wdata = 64'hDEAD_BEEF_0000_0001;
    bus.if_req   = 1'b1;
    bus.if_addr  = 64'h208;
    step();  // cycle 1
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}
        !== {1'b1, 1'b1, 64'h40, 64'hDEAD_BEEF_0000_0001}) begin
      n_fail++;
      $display("FAIL prio_dm_grant got req=%b we=%b addr=%h wd=%h want 1 1 40 deadbeef00000001",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h5555_5555_5555_5555;
    step();  // cycle 2
    bus.mem_ack = 1'b0;
    n_tests++;
    if ({bus.dm_ready, bus.if_ready, bus.mem_req, bus.dm_rdata} !== {3'b100, 64'd0}) begin
      n_fail++;
      $display("FAIL prio_store_resp got dmr=%b ifr=%b req=%b dmd=%h want 1 0 0 0",
               bus.dm_ready, bus.if_ready, bus.mem_req, bus.dm_rdata);
    end
    step();  // cycle 3: IDLE
    bus.dm_req = 1'b0;
    step();  // cycle 4
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 64'h208}) begin
      n_fail++;
      $display("FAIL prio_if_next got req=%b we=%b addr=%h want 1 0 208",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h1357_9BDF_2468_ACE0;
    step();  // cycle 5
    bus.mem_ack = 1'b0;
    n_tests++;
    if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h2468_ACE0}) begin
      n_fail++;
      $display("FAIL prio_if_resp got ifr=%b data=%h want 1 2468ace0",
               bus.if_ready, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_back_to_back_burst();
    bit          exp_dm [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [63:0] r;
    bit          got_dm;
    int          w;
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h1000;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 64'h2000;
    for (int k = 0; k < 6; k++) begin
      w = 0;
      step();
      while (bus.mem_req !== 1'b1 && w < 6) begin
        step();
        w++;
      end
      n_tests++;
      if (bus.mem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_grant_wait[%0d] got no grant want grant", k);
      end
      got_dm = (bus.mem_addr === 64'h2000);
      n_tests++;
      if (got_dm !== exp_dm[k]) begin
        n_fail++;
        $display("FAIL burst_order[%0d] got dm=%b want dm=%b", k, got_dm, exp_dm[k]);
      end
      r = {32'(32'hC0DE_0000 + k), 32'(32'hF00D_0000 + k)};
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = r;
      step();
      bus.mem_ack = 1'b0;
      n_tests++;
      if (exp_dm[k]) begin
        if ({bus.dm_ready, bus.if_ready, bus.dm_rdata} !== {2'b10, r}) begin
          n_fail++;
          $display("FAIL burst_dm_resp[%0d] got dmr=%b ifr=%b dmd=%h want 1 0 %h",
                   k, bus.dm_ready, bus.if_ready, bus.dm_rdata, r);
        end
      end else begin
        if ({bus.if_ready, bus.dm_ready, bus.if_rdata} !== {2'b10, r[31:0]}) begin
          n_fail++;
          $display("FAIL burst_if_resp[%0d] got ifr=%b dmr=%b ifd=%h want 1 0 %h",
                   k, bus.if_ready, bus.dm_ready, bus.if_rdata, r[31:0]);
        end
      end
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    step();
  endtask

  task automatic test_timeout();
    int hi = 0;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 64'h300;
    step();
    while (bus.mem_req === 1'b1 && hi < 20) begin
      hi++;
      step();
    end
    n_tests++;
    if (hi != TO) begin
      n_fail++;
      $display("FAIL timeout_req_len got %0d want %0d", hi, TO);
    end
    n_tests++;
    if ({bus.dm_ready, bus.bus_err, bus.if_ready, bus.dm_rdata} !== {3'b110, 64'd0}) begin
      n_fail++;
      $display("FAIL timeout_abort got dmr=%b err=%b ifr=%b dmd=%h want 1 1 0 0",
               bus.dm_ready, bus.bus_err, bus.if_ready, bus.dm_rdata);
    end
    step();
    bus.dm_req = 1'b0;
    n_tests++;
    if ({bus.dm_ready, bus.bus_err} !== 2'b00) begin
      n_fail++;
      $display("FAIL timeout_pulse_len got dmr=%b err=%b want 0 0", bus.dm_ready, bus.bus_err);
    end
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hFEED_FACE_CAFE_F00D;
    step();
    bus.mem_ack = 1'b0;
    n_tests++;
    if ({bus.dm_ready, bus.if_ready, bus.bus_err, bus.mem_req, bus.dm_rdata} !== 68'd0) begin
      n_fail++;
      $display("FAIL timeout_late_ack got dmr=%b ifr=%b err=%b req=%b dmd=%h want 0 0 0 0 0",
               bus.dm_ready, bus.if_ready, bus.bus_err, bus.mem_req, bus.dm_rdata);
    end
  endtask

  task automatic test_reset_busy();
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h504;
    step();  // cycle 1
    n_tests++;
    if (bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rstbusy_grant got req=%b want 1", bus.mem_req);
    end
    step();  // cycle 2
    rst        = 1'b1;
    bus.if_req = 1'b0;
    step();  // cycle 3
    rst = 1'b0;
    n_tests++;
    if ({bus.mem_req, bus.if_ready, bus.bus_err, bus.if_rdata} !== 35'd0) begin
      n_fail++;
      $display("FAIL rstbusy_clear got req=%b ifr=%b err=%b ifd=%h want 0 0 0 0",
               bus.mem_req, bus.if_ready, bus.bus_err, bus.if_rdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h9999_8888_7777_6666;
    step();  // cycle 4
    bus.mem_ack = 1'b0;
    n_tests++;
    if ({bus.mem_req, bus.if_ready, bus.dm_ready, bus.bus_err, bus.if_rdata} !== 36'd0) begin
      n_fail++;
      $display("FAIL rstbusy_late_ack got req=%b ifr=%b dmr=%b err=%b ifd=%h want 0 0 0 0 0",
               bus.mem_req, bus.if_ready, bus.dm_ready, bus.bus_err, bus.if_rdata);
    end
    bus.if_req  = 1'b1;
    bus.if_addr = 64'h600;
    step();
    n_tests++;
    if ({bus.mem_req, bus.mem_addr} !== {1'b1, 64'h600}) begin
      n_fail++;
      $display("FAIL rstbusy_regrant got req=%b addr=%h want 1 600", bus.mem_req, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h0BAD_0BAD_600D_600D;
    step();
    bus.mem_ack = 1'b0;
    n_tests++;
    if ({bus.if_ready, bus.if_rdata} !== {1'b1, 32'h600D_600D}) begin
      n_fail++;
      $display("FAIL rstbusy_resp got ifr=%b ifd=%h want 1 600d600d", bus.if_ready, bus.if_rdata);
    end
    bus.if_req = 1'b0;
    step();
  endtask

  task automatic test_load_fast();
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 64'h80;
    settle();  // cycle 0
    n_tests++;
    if (bus.pipe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stall_c0 got %b want 1", bus.pipe_stall);
    end
    step();    // cycle 1
    n_tests++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 64'h80}) begin
      n_fail++;
      $display("FAIL load_grant got req=%b we=%b addr=%h want 1 0 80",
               bus.mem_req, bus.mem_we, bus.mem_addr);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
    settle();
    n_tests++;
    if (bus.pipe_stall !== 1'b1) begin
      n_fail++;
      $display("FAIL load_stall_c1 got %b want 1", bus.pipe_stall);
    end
    step();    // cycle 2
    bus.mem_ack = 1'b0;
    settle();
    n_tests++;
    if ({bus.dm_ready, bus.dm_rdata, bus.pipe_stall} !== {1'b1, 64'h0123_4567_89AB_CDEF, 1'b0}) begin
      n_fail++;
      $display("FAIL load_resp got dmr=%b dmd=%h stall=%b want 1 0123456789abcdef 0",
               bus.dm_ready, bus.dm_rdata, bus.pipe_stall);
    end
    step();
    bus.dm_req = 1'b0;
    step();
  endtask

  // Transaction-level reference: arbitration rule, starvation counter,
  // watchdog and data-return rules computed directly per access.
  task automatic test_random();
    bit          if_pend = 0, dm_pend = 0, gdm, acked, dwe = 0, exp_stall;
    logic [63:0] ia = 0, da = 0, dw = 0, r, exp_addr;
    logic [63:0] dm_rdata_m = 64'd0;
    logic [31:0] if_rdata_m = 32'd0;
    int          burst_m = 0, d;
    bit          exp_we;

    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int it = 0; it < 250; it++) begin
      // IDLE cycle
      n_tests++;
      if ({bus.mem_req, bus.if_ready, bus.dm_ready, bus.bus_err} !== 4'b0) begin
        n_fail++;
        $display("FAIL rnd_idle[%0d] got req=%b ifr=%b dmr=%b err=%b want 0 0 0 0",
                 it, bus.mem_req, bus.if_ready, bus.dm_ready, bus.bus_err);
      end
      if (!if_pend && $urandom_range(0, 2) != 0) begin
        if_pend = 1;
        ia = {$urandom, $urandom};
      end
      if (!dm_pend && $urandom_range(0, 2) != 0) begin
        dm_pend = 1;
        da  = {$urandom, $urandom};
        dw  = {$urandom, $urandom};
        dwe = 1'($urandom_range(0, 1));
      end
      bus.if_req    = if_pend;
      bus.if_addr   = ia;
      bus.dm_req    = dm_pend;
      bus.dm_we     = dwe;
      bus.dm_addr   = da;
      bus.dm_wdata  = dw;
      bus.mem_ack   = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = {$urandom, $urandom};
      settle();
      n_tests++;
      if (bus.pipe_stall !== (if_pend | dm_pend)) begin
        n_fail++;
        $display("FAIL rnd_stall_idle[%0d] got %b want %b", it, bus.pipe_stall, if_pend | dm_pend);
      end
      if (!if_pend && !dm_pend) begin
        step();
        continue;
      end

      gdm = dm_pend && (!if_pend || burst_m < MAXB);
      if (gdm) burst_m = if_pend ? ((burst_m + 1 > MAXB) ? MAXB : burst_m + 1) : 0;
      else     burst_m = 0;
      exp_addr = gdm ? (da & ~64'h7) : (ia & ~64'h3);
      exp_we   = gdm ? dwe : 1'b0;
      d        = $urandom_range(1, 10);
      r        = {$urandom, $urandom};
      acked    = 0;

      for (int j = 1; j <= TO; j++) begin
        step();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
        n_tests++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.if_ready, bus.dm_ready, bus.bus_err}
            !== {1'b1, exp_we, exp_addr, 3'b000}) begin
          n_fail++;
          $display("FAIL rnd_busy[%0d.%0d] got req=%b we=%b addr=%h rdy=%b%b err=%b want 1 %b %h 00 0",
                   it, j, bus.mem_req, bus.mem_we, bus.mem_addr, bus.if_ready, bus.dm_ready,
                   bus.bus_err, exp_we, exp_addr);
        end
        if (gdm && dwe) begin
          n_tests++;
          if (bus.mem_wdata !== dw) begin
            n_fail++;
            $display("FAIL rnd_wdata[%0d.%0d] got %h want %h", it, j, bus.mem_wdata, dw);
          end
        end
        if (j == d) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = r;
          acked = 1;
          break;
        end
      end

      step();  // RESP cycle
      bus.mem_ack   = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = {$urandom, $urandom};
      if (gdm) begin
        if (!dwe) dm_rdata_m = acked ? r : 64'd0;
        exp_stall = if_pend;
        n_tests++;
        if ({bus.dm_ready, bus.if_ready, bus.bus_err, bus.mem_req} !== {2'b10, !acked, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_dm_resp[%0d] got dmr=%b ifr=%b err=%b req=%b want 1 0 %b 0",
                   it, bus.dm_ready, bus.if_ready, bus.bus_err, bus.mem_req, !acked);
        end
      end else begin
        if_rdata_m = acked ? (ia[2] ? r[63:32] : r[31:0]) : 32'd0;
        exp_stall = dm_pend;
        n_tests++;
        if ({bus.if_ready, bus.dm_ready, bus.bus_err, bus.mem_req} !== {2'b10, !acked, 1'b0}) begin
          n_fail++;
          $display("FAIL rnd_if_resp[%0d] got ifr=%b dmr=%b err=%b req=%b want 1 0 %b 0",
                   it, bus.if_ready, bus.dm_ready, bus.bus_err, bus.mem_req, !acked);
        end
      end
      n_tests++;
      if ({bus.if_rdata, bus.dm_rdata} !== {if_rdata_m, dm_rdata_m}) begin
        n_fail++;
        $display("FAIL rnd_data[%0d] got ifd=%h dmd=%h want %h %h",
                 it, bus.if_rdata, bus.dm_rdata, if_rdata_m, dm_rdata_m);
      end
      settle();
      n_tests++;
      if (bus.pipe_stall !== exp_stall) begin
        n_fail++;
        $display("FAIL rnd_stall_resp[%0d] got %b want %b", it, bus.pipe_stall, exp_stall);
      end
      if (gdm) dm_pend = 0;
      else     if_pend = 0;
      step();  // back to IDLE
      bus.mem_ack = 1'b0;
    end
    idle_inputs();
    step();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fetch();
    test_dm_priority();
    test_back_to_back_burst();
    test_timeout();
    test_reset_busy();
    test_load_fast();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared 64-bit memory port between the instruction-fetch stage and the MEM-stage data access of the 64-bit pipelined CPU. Requests are serialized through a small FSM that holds the memory interface until it acknowledges, with variable latency. The block returns fetched instructions and load data, and raises a pipeline stall while any requester waits. Data accesses have priority; a burst counter prevents fetch starvation, and a watchdog terminates hung transactions.

## Interface
- MAX_DM_BURST, 4, consecutive data grants allowed while a fetch is pending before fetch is forced
- TIMEOUT, 255, maximum wait cycles for mem_ack before abort (1..255)
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held with if_addr until if_ready
- if_addr  in  64  fetch byte address; bits [1:0] ignored
- if_rdata  out  32  instruction word, valid when if_ready
- if_ready  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held with dm_we/dm_addr/dm_wdata until dm_ready
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  64  data byte address; bits [2:0] ignored
- dm_wdata  in  64  store data
- dm_rdata  out  64  load data, valid when dm_ready and the access was a load
- dm_ready  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request, held high until mem_ack or abort
- mem_we  out  1  memory write enable
- mem_addr  out  64  memory address (latched at grant)
- mem_wdata  out  64  memory write data (latched at grant)
- mem_rdata  in  64  memory read data, valid with mem_ack
- mem_ack  in  1  one-cycle acknowledge from memory
- bus_err  out  1  one-cycle pulse, coincident with the ready pulse of an aborted access
- pipe_stall  out  1  (if_req & ~if_ready) | (dm_req & ~dm_ready), combinational

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE: if dm_req and (if_req==0 or burst_cnt<MAX_DM_BURST), grant DM and go to BUSY_DM. Otherwise, if if_req, grant IF and go to BUSY_IF. With no request, stay in IDLE.
- Grant: latch address, we and wdata into the mem_* registers. mem_we = dm_we for DM and 0 for IF. Set mem_req=1.
- burst_cnt: incremented on a DM grant while if_req=1, saturating at MAX_DM_BURST. Cleared on any IF grant, and on a DM grant while if_req=0.
- BUSY_x: on mem_ack, capture data and go to RESP.
  - IF: if_rdata = mem_rdata[31:0] when latched addr[2]=0, else mem_rdata[63:32].
  - DM load: dm_rdata = mem_rdata. DM store: dm_rdata unchanged.
  - mem_req drops in the same edge.
- Watchdog: wait_cnt clears at grant and increments each BUSY cycle without mem_ack. When wait_cnt reaches TIMEOUT-1 with no ack:
  - go to RESP with error flag set and mem_req deasserted;
  - data outputs are forced to 0 for a load or fetch.
- RESP: pulse the owning x_ready for one cycle, and bus_err if flagged. No grant is issued in RESP, so the requester's still-high req is not re-granted. Next state is IDLE.
- mem_ack outside BUSY_x (late ack after an abort, or after reset) is ignored.
- Only one transaction is outstanding; mem_addr, mem_we and mem_wdata stay stable for the whole BUSY state.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0, bus_err=0, burst_cnt=0, wait_cnt=0. pipe_stall follows its inputs.
- Request seen in IDLE at cycle 0 gives mem_req=1 at cycle 1. mem_ack at cycle k (k≥1) gives x_ready=1 at k+1 and IDLE at k+2, when the next grant decision is made.
- Minimum turnaround per access is 3 cycles (ack at cycle 1).
- Simultaneous if_req and dm_req in IDLE: DM wins unless burst_cnt==MAX_DM_BURST.
- Reset while BUSY or RESP: the next edge gives IDLE, mem_req=0, and no ready pulse. Requesters must reissue.
- Requester dropping req while its access is in flight: the access completes and the ready pulse is still generated.

## Test plan
- Reset, then if_req with if_addr=0x104 and mem_ack at cycle 2 with mem_rdata=0xAAAA_BBBB_1111_2222. Required: mem_req high in cycles 1–2 with mem_addr=0x104; if_ready=1 at cycle 3; if_rdata=0xAAAA_BBBB; IDLE at cycle 4.
- dm_req store with dm_addr=0x40 and dm_wdata=0xDEAD_BEEF_0000_0001, together with if_req at cycle 0. Required: DM granted first, with mem_we=1, mem_addr=0x40 and mem_wdata as given. IF is granted in the first IDLE cycle after dm_ready.
- dm_req held continuously for 6 transactions with if_req high and MAX_DM_BURST=4. Required: grants in order DM, DM, DM, DM, IF, then DM.
- With TIMEOUT=8, issue a load and never ack. Required: mem_req high for exactly 8 cycles; then dm_ready=1, bus_err=1 and dm_rdata=0 together. A mem_ack 2 cycles later has no effect.
- Assert Reset for one cycle in the middle of BUSY_IF. Required: next cycle has mem_req=0 and if_ready=0 with state IDLE, and an ack arriving afterwards is ignored.
- Load at dm_addr=0x80 acked at cycle 1 with mem_rdata=0x0123_4567_89AB_CDEF. Required: dm_ready at cycle 2 with dm_rdata=0x0123_4567_89AB_CDEF, and pipe_stall=1 during cycles 0–1.
